// File: rtl/upcounter_ctrl_pkg.sv
// upcounter_ctrl_pkg
//   Shared definitions for the up-counter sequencing controller:
//   the FSM state width and the state codes (also visible on the
//   controller's debug "state" output).
package upcounter_ctrl_pkg;

  localparam int STATE_W = 3;

  // Codes 5..7 are unused; the controller treats them as illegal and
  // returns to ST_IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/upcounter_ctrl_tff.sv
// tff_count4
//   Synchronous up-counter built from a chain of T flip-flops.
//   Bit i toggles when en is high and all lower bits are one.
// Ports:
//   clk   rising-edge clock
//   reset asynchronous, active-low; clears q
//   clr   synchronous clear, wins over en
//   en    count enable
//   q     counter value
module tff_count4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] t;

  assign t[0] = en;

  // Each toggle term is built from the enable and an AND of the lower
  // bits directly, rather than from t[i-1], so no bit of t depends on
  // another bit of the same vector.
  for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
    assign t[i] = en & (&q[i-1:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/upcounter_ctrl.sv
// upcounter_ctrl
//   Sequencing controller that turns the T-FF up-counter into a
//   programmable interval timer: start latches a terminal count and
//   reload mode, the counter is cleared, counts up to the terminal
//   count, then either finishes (done pulse) or wraps to 0 (tick pulse).
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low
//   start   command pulse, accepted only in IDLE with abort low
//   limit   terminal count, latched on accepted start
//   reload  auto-reload mode, latched on accepted start
//   pause   level; freezes counting in RUN/HOLD
//   abort   cancels an active run (priority over pause/terminal/start)
//   q       counter value
//   cnt_en  enable currently applied to the counter
//   busy    high in CLEAR, RUN, HOLD
//   done    one-cycle pulse while in DONE
//   tick    one-cycle registered pulse after each reload wrap
//   state   FSM state code
//
// Handshake: there is no ready signal. start is a request that is taken
// only when the FSM is in IDLE and abort is low on the same edge; in any
// other state it is dropped. Completion is reported by done (one cycle),
// and busy covers the whole interval from acceptance to completion.
module upcounter_ctrl
  import upcounter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   limit,
  input  logic               reload,
  input  logic               pause,
  input  logic               abort,
  output logic [WIDTH-1:0]   q,
  output logic               cnt_en,
  output logic               busy,
  output logic               done,
  output logic               tick,
  output logic [STATE_W-1:0] state
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] limit_r;
  logic             reload_r;
  logic             tick_q;
  logic             latch;
  logic             clr;
  logic             en;
  logic             wrap;

  tff_count4 #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .q     (q)
  );

  // Next-state and counter control. The terminal compare looks at q
  // before any increment, so the counter stops at limit_r and never
  // wraps modulo 2^WIDTH.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          latch   = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          clr     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (q != limit_r) begin
          en = 1'b1;
        end else if (reload_r) begin
          clr  = 1'b1;
          wrap = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      limit_r  <= '0;
      reload_r <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= wrap;
      if (latch) begin
        limit_r  <= limit;
        reload_r <= reload;
      end
    end
  end

  assign cnt_en = en;
  assign busy   = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                  (state_q == ST_HOLD);
  assign done   = (state_q == ST_DONE);
  assign tick   = tick_q;
  assign state  = state_q;

endmodule

// File: tb/tb_upcounter_ctrl.sv
// tb_upcounter_ctrl
//   Bench for upcounter_ctrl. Each scenario task pushes the expected
//   {tick, state, q} after every clock edge into exp_q while it drives
//   stimulus, then pops and compares once the edge has passed.
module tb_upcounter_ctrl;

  localparam int WIDTH = 4;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             reload;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             cnt_en;
  logic             busy;
  logic             done;
  logic             tick;
  logic [2:0]       state;

  logic [WIDTH+3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  upcounter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .limit  (limit),
    .reload (reload),
    .pause  (pause),
    .abort  (abort),
    .q      (q),
    .cnt_en (cnt_en),
    .busy   (busy),
    .done   (done),
    .tick   (tick),
    .state  (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH+3:0] pack(input logic t, input logic [2:0] s,
                                            input logic [WIDTH-1:0] v);
    return {t, s, v};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if ({q, cnt_en, busy, done, tick, state} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE}) begin
      failures++;
      $display("FAIL reset_state got q=%0d en=%b busy=%b done=%b tick=%b state=%0d exp all zero",
               q, cnt_en, busy, done, tick, state);
    end
  endtask

  // Non-reload run: RUN q=0..lim, DONE at start-edge+lim+2, IDLE after.
  task automatic test_single(input string name, input logic [WIDTH-1:0] lim);
    logic [WIDTH+3:0] e;
    int dones = 0;
    limit = lim; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    limit = WIDTH'($urandom_range(0, 15));   // must be ignored after latch
    reload = 1'b1;                           // must be ignored after latch
    checks++;
    if (state !== S_CLEAR || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s clear got state=%0d busy=%b exp state=1 busy=1", name, state, busy);
    end
    for (int k = 0; k <= int'(lim); k++) exp_q.push_back(pack(1'b0, S_RUN, k[WIDTH-1:0]));
    exp_q.push_back(pack(1'b0, S_DONE, lim));
    exp_q.push_back(pack(1'b0, S_IDLE, lim));
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({tick, state, q} !== e) begin
        failures++;
        $display("FAIL %s seq got tick/state/q=%h exp=%h", name, {tick, state, q}, e);
      end
      checks++;
      if (done !== (e[6:4] == S_DONE) || busy !== (e[6:4] == S_RUN) ||
          cnt_en !== (e[6:4] == S_RUN && e[3:0] != lim)) begin
        failures++;
        $display("FAIL %s flags got done=%b busy=%b en=%b for exp state=%0d q=%0d",
                 name, done, busy, cnt_en, e[6:4], e[3:0]);
      end
      if (done === 1'b1) dones++;
    end
    reload = 1'b0;
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL %s done_count got=%0d exp=1", name, dones);
    end
  endtask

  // Reload run for 13 cycles, then abort out of it.
  task automatic test_reload(input string name, input logic [WIDTH-1:0] lim);
    logic [WIDTH+3:0] e;
    int r;
    limit = lim; reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 13; c++) begin
      r = c % (int'(lim) + 1);
      exp_q.push_back(pack(c > 0 && r == 0, S_RUN, r[WIDTH-1:0]));
    end
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({tick, state, q} !== e || done !== 1'b0) begin
        failures++;
        $display("FAIL %s seq got tick/state/q=%h done=%b exp=%h done=0",
                 name, {tick, state, q}, done, e);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (state !== S_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s abort_exit got state=%0d busy=%b done=%b exp 0/0/0", name, state, busy, done);
    end
    reload = 1'b0;
  endtask

  // limit=6, pause sampled high on two edges while q=2: q sits at 2 for
  // three extra cycles and DONE moves from start-edge+8 to start-edge+11.
  task automatic test_pause();
    logic [WIDTH+3:0] e;
    logic [2:0] sts[12] = '{S_RUN, S_RUN, S_RUN, S_HOLD, S_HOLD, S_RUN,
                            S_RUN, S_RUN, S_RUN, S_RUN, S_DONE, S_IDLE};
    logic [3:0] qs[12]  = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
                            4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6};
    int done_edge = -1;
    limit = 4'd6; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) exp_q.push_back(pack(1'b0, sts[i], qs[i]));
    for (int i = 1; i <= 12; i++) begin
      pause = (i == 4 || i == 5);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({tick, state, q} !== e) begin
        failures++;
        $display("FAIL pause seq edge=+%0d got tick/state/q=%h exp=%h", i, {tick, state, q}, e);
      end
      checks++;
      if (cnt_en !== (e[6:4] == S_RUN && e[3:0] != 4'd6 && !pause)) begin
        failures++;
        $display("FAIL pause cnt_en edge=+%0d got=%b", i, cnt_en);
      end
      if (done === 1'b1 && done_edge < 0) done_edge = i;
    end
    pause = 1'b0;
    checks++;
    if (done_edge != 11) begin
      failures++;
      $display("FAIL pause done_edge got=+%0d exp=+11", done_edge);
    end
  endtask

  // limit=9, a second start during the run is ignored, abort at q=4.
  task automatic test_abort();
    logic [WIDTH+3:0] e;
    int dones = 0;
    limit = 4'd9; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back(pack(1'b0, S_RUN, k[WIDTH-1:0]));
    for (int k = 0; k < 4; k++) exp_q.push_back(pack(1'b0, S_IDLE, 4'd4));
    for (int i = 1; i <= 9; i++) begin
      start = (i == 3) || (i == 6) || (i == 7);
      if (i == 3) begin limit = 4'd2; reload = 1'b1; end
      abort = (i == 6) || (i == 7);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({tick, state, q} !== e) begin
        failures++;
        $display("FAIL abort seq edge=+%0d got tick/state/q=%h exp=%h", i, {tick, state, q}, e);
      end
      if (done === 1'b1) dones++;
    end
    start = 1'b0; abort = 1'b0; reload = 1'b0;
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort no_done got dones=%0d busy=%b exp 0/0", dones, busy);
    end
  endtask

  // Reset pulled low mid-run at q=7 must take effect between edges.
  task automatic test_async_reset();
    limit = 4'd12; reload = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (q !== 4'd7 || state !== S_RUN) begin
      failures++;
      $display("FAIL rst_pre got q=%0d state=%0d exp q=7 state=2", q, state);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0 || busy !== 1'b0 || state !== S_IDLE || done !== 1'b0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got q=%0d busy=%b state=%0d done=%b tick=%b exp zeros",
               q, busy, state, done, tick);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    checks++;
    if (state !== S_IDLE || q !== 4'd0) begin
      failures++;
      $display("FAIL rst_idle got state=%0d q=%0d exp 0/0", state, q);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    reset = 1'b0; start = 1'b0; limit = '0; reload = 1'b0; pause = 1'b0; abort = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    test_single("lim5", 4'd5);
    test_single("lim15", 4'd15);
    test_reload("reload3", 4'd3);
    test_reload("reload0", 4'd0);
    test_pause();
    test_abort();
    test_async_reset();
    test_single("lim0", 4'd0);
    for (int n = 0; n < 3; n++) test_single("lim_rand", WIDTH'($urandom_range(1, 14)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
